// File: rtl/rx_frame_sync.sv
`timescale 1ns/1ps
// Byte-stream frame synchronizer: finds the sync word at any bit offset and either polarity,
// re-aligns and de-inverts the bytes that follow, and emits the length-prefixed payload with out_last.
module rx_frame_sync #(
  parameter logic [31:0] SYNC_WORD  = 32'h1ACFFC1D,
  parameter int          SYNC_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        locked,
  output logic        inverted,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int SW = SYNC_WIDTH + 7;
  localparam logic [SYNC_WIDTH-1:0] SYNC = SYNC_WORD[SYNC_WIDTH-1:0];

  typedef enum logic [1:0] {SEARCH, HEADER, PAYLOAD} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      k_q, k_d;
  logic            inv_q, inv_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic            accept;
  logic [SW-1:0]   s_new;
  logic [7:0]      aligned;
  logic            hit;
  logic [2:0]      hit_k;
  logic            hit_inv;

  assign in_ready = (state_q == PAYLOAD) ? (!out_valid_q || out_ready) : 1'b1;

  always_comb begin
    accept  = in_valid && in_ready;
    s_new   = {s_q[SYNC_WIDTH-2:0], in_data};
    aligned = s_new[k_q +: 8] ^ {8{inv_q}};

    // Lowest offset wins; at a given offset the true polarity is tested first.
    hit     = 1'b0;
    hit_k   = 3'd0;
    hit_inv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!hit) begin
        if (s_new[k +: SYNC_WIDTH] == SYNC) begin
          hit     = 1'b1;
          hit_k   = 3'(k);
          hit_inv = 1'b0;
        end else if (s_new[k +: SYNC_WIDTH] == ~SYNC) begin
          hit     = 1'b1;
          hit_k   = 3'(k);
          hit_inv = 1'b1;
        end
      end
    end

    state_d     = state_q;
    s_d         = s_q;
    k_d         = k_q;
    inv_d       = inv_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      s_d = s_new;
      case (state_q)
        SEARCH: begin
          if (hit) begin
            k_d     = hit_k;
            inv_d   = hit_inv;
            state_d = HEADER;
          end
        end
        HEADER: begin
          if (aligned == 8'd0) begin
            err_cnt_d = err_cnt_q + 16'd1;
            state_d   = SEARCH;
          end else begin
            cnt_d   = aligned;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          out_valid_d = 1'b1;
          out_data_d  = aligned;
          out_last_d  = (cnt_q == 8'd1);
          cnt_d       = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      s_q         <= '0;
      k_q         <= 3'd0;
      inv_q       <= 1'b0;
      cnt_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      k_q         <= k_d;
      inv_q       <= inv_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign locked    = (state_q != SEARCH);
  assign inverted  = inv_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rx_frame_sync.sv
`timescale 1ns/1ps
// Scoreboard bench for rx_frame_sync: directed frames push expected payload bytes, a monitor pops on each output handshake.
module tb_rx_frame_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        locked;
  logic        inverted;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  rx_frame_sync dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .locked(locked), .inverted(inverted), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output backpressure pattern generator
  bit bp_en = 1'b0;
  int bp_i  = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial forever begin
    @(posedge clk); #1;
    if (bp_en) begin
      out_ready = pat[bp_i];
      bp_i = (bp_i + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: pops on handshake, checks stability while stalled
  bit         held = 1'b0;
  logic [8:0] held_v;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({out_data, out_last}), 32'(held_v));
      end
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 32'({out_data, out_last}), 32'h1ff);
          end else begin
            e = sb.pop_front();
            check("out_byte", 32'({out_data, out_last}), 32'({e.d, e.l}));
          end
        end else begin
          held   = 1'b1;
          held_v = {out_data, out_last};
          if (locked) check("in_ready_full", 32'(in_ready), 32'd0);
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic l);
    exp_t x;
    x.d = d;
    x.l = l;
    sb.push_back(x);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_sync();
    send(8'h1A); send(8'hCF); send(8'hFC); send(8'h1D);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic push_abc();
    push(8'hAA, 1'b0); push(8'hBB, 1'b0); push(8'hCC, 1'b1);
  endtask

  logic [71:0] shifted;

  initial begin
    // Reset state
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_inverted", 32'(inverted), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Byte-aligned frame
    push_abc();
    send_sync();
    send(8'h03);
    check("aligned_locked_hdr", 32'(locked), 32'd1);
    send(8'hAA); send(8'hBB); send(8'hCC);
    check("aligned_last_now", 32'({out_valid, out_data, out_last}), 32'h399);
    drain("aligned_drain");
    check("aligned_frame_cnt", 32'(frame_cnt), 32'd1);
    check("aligned_inverted", 32'(inverted), 32'd0);
    check("aligned_locked_end", 32'(locked), 32'd0);

    // Same stream delayed by 3 bits
    do_reset();
    push_abc();
    shifted = {64'h1ACFFC1D03AABBCC, 8'h00} >> 3;
    for (int i = 0; i < 9; i++) send(shifted[71 - 8*i -: 8]);
    drain("offset_drain");
    check("offset_frame_cnt", 32'(frame_cnt), 32'd1);
    check("offset_k", 32'(dut.k_q), 32'd5);
    check("offset_inverted", 32'(inverted), 32'd0);

    // Inverted polarity
    do_reset();
    push_abc();
    send(8'hE5); send(8'h30); send(8'h03); send(8'hE2);
    send(8'hFC); send(8'h55); send(8'h44); send(8'h33);
    drain("inv_drain");
    check("inv_inverted", 32'(inverted), 32'd1);
    check("inv_frame_cnt", 32'(frame_cnt), 32'd1);

    // Output backpressure
    do_reset();
    bp_i  = 0;
    bp_en = 1'b1;
    push_abc();
    send_sync();
    send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
    drain("bp_drain");
    bp_en = 1'b0;
    check("bp_frame_cnt", 32'(frame_cnt), 32'd1);

    // Zero-length header then a one-byte frame
    do_reset();
    push(8'h77, 1'b1);
    send_sync();
    send(8'h00);
    check("zl_err_cnt_mid", 32'(err_cnt), 32'd1);
    check("zl_locked_mid", 32'(locked), 32'd0);
    send_sync();
    send(8'h01); send(8'h77);
    drain("zl_drain");
    check("zl_err_cnt", 32'(err_cnt), 32'd1);
    check("zl_frame_cnt", 32'(frame_cnt), 32'd1);

    // Reset in the middle of a payload
    do_reset();
    push(8'hAA, 1'b0);
    send_sync();
    send(8'h03); send(8'hAA);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_sb", 32'(sb.size()), 32'd0);
    rst = 1'b0;
    push_abc();
    send_sync();
    send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
    drain("post_rst_drain");
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rx_frame_sync.md
Name: rx_frame_sync

Overview:
- Byte-stream frame synchronizer directly downstream of RX_path_top; consumes its 8-bit demodulated output.
- Searches the bit stream for a sync word at any bit offset, in both true and inverted polarity, to resolve 180° carrier ambiguity.
- Re-aligns and de-inverts the following bytes, reads a one-byte length header, and emits the payload as an AXI-Stream-style packet with out_last.

Parameters:
- SYNC_WORD, 32'h1ACFFC1D, sync pattern, MSB transmitted first.
- SYNC_WIDTH, 32, sync pattern width in bits (8..32, multiple of 8 not required).

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input byte valid (from RX_path_top out_valid).
- in_ready  out  1  input byte accepted when in_valid & in_ready.
- in_data  in  8  input byte, MSB is earliest bit.
- out_valid  out  1  output payload byte valid.
- out_ready  in  1  downstream ready.
- out_data  out  8  aligned, polarity-corrected payload byte.
- out_last  out  1  marks final payload byte of a frame.
- locked  out  1  high in HEADER and PAYLOAD states.
- inverted  out  1  polarity of the current lock (1 = inverted sync matched).
- frame_cnt  out  16  completed frames, wraps at 0xFFFF->0.
- err_cnt  out  16  zero-length headers seen, wraps.

Behaviour:
- Reset (synchronous, active-high): state = SEARCH; shift register S cleared; out_valid = 0, out_data = 0, out_last = 0, locked = 0, inverted = 0, frame_cnt = 0, err_cnt = 0, in_ready = 1 from the first cycle after reset.
- Reset mid-frame aborts the frame immediately. No out_last is generated for the aborted frame.
- Shift register: S is SYNC_WIDTH+7 bits wide. On every accepted byte, S <= {S[SYNC_WIDTH-2:0], in_data}, i.e. shift left by 8 and drop the oldest bits.
- SEARCH: after each accept, test offsets k = 0..7 against S_new[k+SYNC_WIDTH-1:k].
  - A match to SYNC_WORD or to ~SYNC_WORD captures k and inverted, then moves to HEADER.
  - Priority: smallest k first; at equal k, non-inverted wins.
  - in_ready = 1.
- Aligned byte: A = S_new[k+7:k] ^ {8{inverted}}, evaluated on each accept after lock.
- HEADER: in_ready = 1. The next accepted byte gives length L = A.
  - L = 0: err_cnt++, return to SEARCH. The S contents are retained and the search continues on the next byte.
  - L ≠ 0: load payload counter with L, go to PAYLOAD.
- PAYLOAD: in_ready = !out_valid | out_ready (one-entry output register; full throughput when out_ready = 1).
  - On accept: out_data <= A, out_valid <= 1, counter--.
  - out_last <= (counter == 1).
  - On the accept of the last byte, frame_cnt++ and go to SEARCH.
  - Search resumes on the next accept. An overlapping sync inside the payload is ignored.
- Output handshake:
  - out_valid is held with out_data and out_last stable until out_ready.
  - It clears on handshake unless a new byte is accepted in the same cycle. Simultaneous handshake and accept reloads the register.
- Latency: one clk from input accept to out_valid.
- The output register may still hold the last byte while SEARCH runs. in_ready = 1 in SEARCH regardless of out_ready.
- locked = (state != SEARCH). inverted holds its value until the next lock.

Test Plan:
- Aligned frame: bytes 1A CF FC 1D 03 AA BB CC, out_ready = 1 → out AA, BB, CC on consecutive cycles, out_last only with CC; frame_cnt = 1, inverted = 0, locked drops after CC.
- Bit offset: the same bit stream prefixed with 3 zero bits and padded with trailing zeros to whole bytes → identical output AA BB CC; captured k = 5.
- Inverted: bytes E5 30 03 E2 FC 55 44 33 → out AA BB CC, inverted = 1, frame_cnt = 1.
- Backpressure: aligned frame with out_ready toggling 1,0,0,1,… → each byte held stable while out_ready = 0; in_ready low while the register is full; no loss or duplication; AA BB CC delivered in order.
- Zero length, then a valid frame: 1A CF FC 1D 00 1A CF FC 1D 01 77 → err_cnt = 1, a single output 77 with out_last, frame_cnt = 1.
- Reset mid-payload: assert rst after AA is output in a 3-byte frame → next cycle out_valid = 0, locked = 0, frame_cnt = 0; a following aligned frame decodes normally.
